adder_result_buffer: RTL
========================

// Module: adder_result_buffer
// PURPOSE
//   Downstream stage of the 8-bit pipelined adder. Captures each valid {cout,sum} result
//   into a FIFO and hands results to the consumer over a valid/ready handshake.
//   Keeps a running modular total and a count of consumed results.
//   Drives pause_signal back to the adder early enough to absorb results still in flight.
// PARAMETERS
//   DEPTH  8   FIFO entries; power of two, >= 2
//   SKID   4   headroom reserved for in-flight adder results; 1 <= SKID < DEPTH
//   ACC_W  16  width of acc_total, also used for acc_count; >= 9
// PORTS
//   clk           in   1      rising-edge clock
//   rst           in   1      synchronous reset, active-high
//   in_valid      in   1      in_sum/in_cout hold a real adder result this cycle
//   in_sum        in   8      adder sum
//   in_cout       in   1      adder carry-out
//   flush_signal  in   1      discard all buffered results
//   out_ready     in   1      consumer accepts out_data this cycle
//   out_valid     out  1      out_data is valid
//   out_data      out  9      {cout,sum} at FIFO head
//   pause_signal  out  1      backpressure to adder (stall request)
//   full          out  1      count == DEPTH
//   overflow      out  1      sticky: a result was dropped
//   acc_total     out  ACC_W  running sum of popped out_data, zero-extended
//   acc_count     out  ACC_W  number of popped results
// BEHAVIOUR
//   Reset (rst=1 at posedge): pointers, count, overflow, acc_total, acc_count := 0.
//     Outputs that cycle: out_valid=0, full=0, pause_signal=0. Reset beats flush, push and pop.
//   Storage: circular buffer with rd_ptr, wr_ptr (log2 DEPTH bits, wrap DEPTH-1 -> 0).
//     Count is 0..DEPTH.
//   push = in_valid & !flush_signal & (count<DEPTH | pop).
//   pop  = out_valid & out_ready.
//   out_valid = (count!=0) & !flush_signal. Combinational; out_data = mem[rd_ptr].
//   No bypass: a push into an empty FIFO becomes visible on out_valid the next cycle.
//   Latency in->out is 1 cycle minimum.
//   Simultaneous push and pop: both happen and count is unchanged. This holds when full
//     (the slot is freed and refilled in the same cycle) and when count == 1.
//   Full and no pop: an in_valid result is dropped, overflow := 1 (sticky).
//     Only rst clears overflow.
//   flush_signal=1: next cycle count=0 and rd_ptr=wr_ptr=0.
//     A concurrent in_valid is discarded and overflow is NOT set.
//     No pop occurs. acc_total, acc_count and overflow are unchanged.
//   pause_signal = (count >= DEPTH-SKID). Combinational from registered count; never
//     from in_valid. Upstream keeps at most SKID results in flight after pause rises.
//   On every pop, registered updates:
//     acc_total := acc_total + {{ACC_W-9}{0}, out_data}, modulo 2^ACC_W.
//     acc_count := acc_count + 1, modulo 2^ACC_W.
//   full = (count==DEPTH). Reset mid-operation discards contents; no partial state survives.
// TESTING
//   1 After rst, with out_ready=0, push {0,12h},{1,FFh},{0,00h} -> count=3, out_data=012h.
//     Then set out_ready=1 for 3 cycles -> pops 012h,1FFh,000h in order;
//     acc_total=0211h, acc_count=3, out_valid=0.
//   2 With DEPTH=8, SKID=4 and out_ready=0, push 9 results -> pause_signal rises after
//     the 4th push, full=1 after the 8th, 9th is dropped, overflow=1, count stays 8,
//     head unchanged.
//   3 Full FIFO with in_valid=1 and out_ready=1 for 8 cycles -> count stays 8,
//     overflow stays 0, pop order equals push order.
//   4 Hold 5 entries, assert flush_signal with in_valid=1 -> out_valid=0 that cycle;
//     next cycle count=0, pause_signal=0, acc_total/acc_count unchanged.
//     The next push appears at out_data after 1 cycle.
//   5 Push/pop {1,FFh} 129 times -> acc_total=017Fh (65919 mod 65536), acc_count=0081h.
//   6 rst asserted with 6 entries, overflow=1, acc_total!=0 -> next cycle every output
//     and counter is 0, and a push right after reset reads back correctly.

Source files
------------

// File: rtl/adder_result_buffer.sv
// -----------------------------------------------------------------------------
// adder_result_buffer
//   Downstream stage of the 8-bit pipelined adder. Each valid {cout,sum} result
//   is captured into a circular FIFO and handed to the consumer over a
//   valid/ready handshake. The block keeps a running modular total of consumed
//   results and a count of them. It also asks the adder to pause early enough
//   that results already in flight still fit.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid          in_sum/in_cout carry a real adder result this cycle
//   in_sum, in_cout   adder result
//   flush_signal      discard every buffered result (and any concurrent input)
//   out_ready         consumer accepts out_data this cycle
//   out_valid         out_data holds the FIFO head
//   out_data          {cout,sum} at the FIFO head
//   pause_signal      stall request to the adder (count >= DEPTH-SKID)
//   full              count == DEPTH
//   overflow          sticky: a result arrived while full with no pop
//   acc_total         running sum of popped out_data, modulo 2^ACC_W
//   acc_count         number of popped results, modulo 2^ACC_W
//
// Handshake: a transfer happens on a rising edge where out_valid && out_ready;
// out_valid does not depend on out_ready, and out_data is stable while
// out_valid is high and no transfer has happened.
// -----------------------------------------------------------------------------
module adder_result_buffer #(
  parameter int DEPTH = 8,
  parameter int SKID  = 4,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_sum,
  input  logic             in_cout,
  input  logic             flush_signal,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [8:0]       out_data,
  output logic             pause_signal,
  output logic             full,
  output logic             overflow,
  output logic [ACC_W-1:0] acc_total,
  output logic [ACC_W-1:0] acc_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] PAUSE_CNT = (AW+1)'(DEPTH - SKID);

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  // Status outputs come from the registered count only. They are forced low
  // while rst is high so the reset cycle itself shows an idle buffer.
  assign out_valid    = (count != '0) & ~flush_signal & ~rst;
  assign out_data     = mem[rd_ptr];
  assign full         = (count == FULL_CNT) & ~rst;
  assign pause_signal = (count >= PAUSE_CNT) & ~rst;

  assign pop  = out_valid & out_ready;
  // When full, a concurrent pop frees the head slot. That slot is the one
  // wr_ptr points at, so it is refilled in the same cycle.
  assign push = in_valid & ~flush_signal & ~rst & ((count != FULL_CNT) | pop);

  // Storage is not reset; validity is carried entirely by count/pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_cout, in_sum};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      acc_total <= '0;
      acc_count <= '0;
    end else if (flush_signal) begin
      // Flush wins over push and pop; the accumulators and overflow are kept.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Outside reset and flush, a rejected in_valid means full with no pop.
      if (in_valid & ~push) overflow <= 1'b1;
      if (pop) begin
        acc_total <= acc_total + ACC_W'(out_data);
        acc_count <= acc_count + 1'b1;
      end
    end
  end

endmodule
